// File: rtl/regfile_arb_pkg.sv
// Shared constants for the register-file read arbiter: default geometry and the
// hard-wired zero register address.
package regfile_arb_pkg;

  localparam int DEF_NREQ = 4;
  localparam int DEF_AW   = 5;
  localparam int DEF_DW   = 32;

  // Register 0 reads as a constant, so a write to it must never be forwarded.
  localparam logic [DEF_AW-1:0] REG_ZERO = 5'd0;

  // Wrap an index that may have stepped at most one period past n.
  function automatic int unsigned rr_wrap(input int unsigned idx, input int unsigned n);
    return (idx >= n) ? (idx - n) : idx;
  endfunction

endpackage

// File: rtl/regfile_read_arbiter_if.sv
// Bundle between read clients, the external read mux, the writeback port and the
// arbiter. The slave modport is the arbiter's view; master is the surrounding pipeline.
interface regfile_read_arbiter_if #(
  parameter int NREQ = 4,
  parameter int AW   = 5,
  parameter int DW   = 32
);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ-1:0]    req_ready;

  logic [AW-1:0]      mux_sel;
  logic [DW-1:0]      mux_data;

  logic               wr_en;
  logic [AW-1:0]      wr_addr;
  logic [DW-1:0]      wr_data;

  logic [NREQ-1:0]    rsp_valid;
  logic [DW-1:0]      rsp_data;

  modport slave (
    input  req_valid, req_addr, mux_data, wr_en, wr_addr, wr_data,
    output req_ready, mux_sel, rsp_valid, rsp_data
  );

  modport master (
    output req_valid, req_addr, mux_data, wr_en, wr_addr, wr_data,
    input  req_ready, mux_sel, rsp_valid, rsp_data
  );

endinterface

// File: rtl/regfile_read_arbiter_rr_pick.sv
// Combinational round-robin picker: scans from last_i+1 upward (wrapping) and
// returns the first asserted request as one-hot, encoded index and a found flag.
module rr_pick
  import regfile_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   last_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IW-1:0]   idx_o,
  output logic            any_o
);

  int unsigned   cand;
  logic [IW-1:0] cand_idx;

  always_comb begin
    grant_o  = '0;
    idx_o    = '0;
    any_o    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned off = 1; off <= NREQ; off++) begin
      cand     = rr_wrap(32'(last_i) + off, NREQ);
      cand_idx = cand[IW-1:0];
      if (!any_o && req_i[cand_idx]) begin
        grant_o[cand_idx] = 1'b1;
        idx_o             = cand_idx;
        any_o             = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_read_arbiter.sv
// Two-stage read arbiter: stage A grants one requester and drives the mux select,
// stage B captures the mux output (or same-cycle writeback data) for that requester.
module regfile_read_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int AW   = DEF_AW,
  parameter int DW   = DEF_DW
) (
  input logic                  clk,
  input logic                  rst,
  regfile_read_arbiter_if.slave bus
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0] grant;
  logic [IW-1:0]   win_idx;
  logic            any_grant;
  logic [AW-1:0]   addr_arr [NREQ];
  logic [AW-1:0]   win_addr;
  logic            fwd_hit;

  logic [AW-1:0]   mux_sel_q,   mux_sel_d;
  logic [IW-1:0]   own_q,       own_d;
  logic [IW-1:0]   last_q,      last_d;
  logic            a_vld_q,     a_vld_d;
  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]   rsp_data_q,  rsp_data_d;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_addr
      assign addr_arr[gi] = bus.req_addr[gi*AW +: AW];
    end
  endgenerate

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req_i   (bus.req_valid),
    .last_i  (last_q),
    .grant_o (grant),
    .idx_o   (win_idx),
    .any_o   (any_grant)
  );

  assign win_addr = addr_arr[win_idx];

  // Writes to the zero register are dropped by the file, so they must not forward.
  assign fwd_hit = bus.wr_en && (bus.wr_addr == mux_sel_q) && (mux_sel_q != AW'(REG_ZERO));

  always_comb begin
    mux_sel_d   = mux_sel_q;
    own_d       = own_q;
    last_d      = last_q;
    a_vld_d     = 1'b0;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;

    if (any_grant) begin
      mux_sel_d = win_addr;
      own_d     = win_idx;
      last_d    = win_idx;
      a_vld_d   = 1'b1;
    end

    if (a_vld_q) begin
      rsp_valid_d = NREQ'(1) << own_q;
      rsp_data_d  = fwd_hit ? bus.wr_data : bus.mux_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mux_sel_q   <= '0;
      own_q       <= '0;
      last_q      <= IW'(NREQ - 1);
      a_vld_q     <= 1'b0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      mux_sel_q   <= mux_sel_d;
      own_q       <= own_d;
      last_q      <= last_d;
      a_vld_q     <= a_vld_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign bus.req_ready = grant;
  assign bus.mux_sel   = mux_sel_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;

  a_grant_onehot : assert property (@(posedge clk) disable iff (rst) $onehot0(bus.req_ready));
  a_rsp_onehot   : assert property (@(posedge clk) disable iff (rst) $onehot0(bus.rsp_valid));

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Directed bench for regfile_read_arbiter: reset, single read, rotation,
// forwarding and idle gaps with hand-computed expectations.
module tb_regfile_read_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 5;
  localparam int DW   = 32;

  logic clk;
  logic rst;
  logic          mux_force_en;
  logic [DW-1:0] mux_force;

  int n_checks;
  int n_fail;

  regfile_read_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

  regfile_read_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mux_val(input logic [4:0] a);
    return {16'hDEAD, 11'd0, a};
  endfunction

  // Read-mux model: register r holds 0xDEAD_00rr unless overridden.
  always_comb begin
    bus.mux_data = mux_force_en ? mux_force : mux_val(bus.mux_sel);
  end

  always @(negedge clk) begin
    if (!rst && |bus.rsp_valid)
      $display("txn rsp owner=%b data=%h", bus.rsp_valid, bus.rsp_data);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int i, input logic [4:0] a);
    bus.req_addr[i*AW +: AW] = a;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    mux_force_en = 1'b0;
    mux_force = '0;
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.wr_en     = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;

    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_mux_sel",   32'(bus.mux_sel),   32'd0);
    check_eq("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_eq("reset_rsp_data",  bus.rsp_data,       32'd0);
    check_eq("reset_req_ready", 32'(bus.req_ready), 32'd0);
    rst = 1'b0;

    // Round robin: all four request continuously at addresses 10..13.
    for (int i = 0; i < NREQ; i++) set_addr(i, 5'(10 + i));
    bus.req_valid = 4'hF;
    #1;
    for (int n = 0; n < 7; n++) begin
      check_eq("rr_ready", 32'(bus.req_ready), 32'(1) << (n % 4));
      if (n >= 1)
        check_eq("rr_mux_sel", 32'(bus.mux_sel), 32'(10 + ((n - 1) % 4)));
      if (n >= 2) begin
        check_eq("rr_rsp_valid", 32'(bus.rsp_valid), 32'(1) << ((n - 2) % 4));
        check_eq("rr_rsp_data",  bus.rsp_data, mux_val(5'(10 + ((n - 2) % 4))));
      end
      step();
    end

    // Reset with one response on the output and one grant in stage B.
    rst = 1'b1;
    #1;
    check_eq("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_eq("rst_mux_sel",   32'(bus.mux_sel),   32'd0);
    check_eq("rst_ready",     32'(bus.req_ready), 32'h1);
    bus.req_valid = '0;
    step();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check_eq("post_rst_no_rsp", 32'(bus.rsp_valid), 32'd0);
    end
    bus.req_valid = 4'hF;
    #1;
    check_eq("post_rst_first_grant", 32'(bus.req_ready), 32'h1);
    step();
    bus.req_valid = '0;
    step();
    check_eq("post_rst_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    check_eq("post_rst_rsp_data",  bus.rsp_data, mux_val(5'd10));

    // Single read by requester 2 at address 9.
    set_addr(2, 5'd9);
    bus.req_valid = 4'b0100;
    #1;
    check_eq("single_ready", 32'(bus.req_ready), 32'b0100);
    step();
    bus.req_valid = '0;
    check_eq("single_mux_sel",  32'(bus.mux_sel),   32'd9);
    check_eq("single_no_rsp_yet", 32'(bus.rsp_valid), 32'd0);
    step();
    check_eq("single_rsp_valid", 32'(bus.rsp_valid), 32'b0100);
    check_eq("single_rsp_data",  bus.rsp_data, 32'hDEAD_0009);
    step();
    check_eq("single_pulse_end", 32'(bus.rsp_valid), 32'd0);
    check_eq("single_data_hold", bus.rsp_data, 32'hDEAD_0009);

    // Forwarding on address 7 (requester 0; search starts at 3 after grant 2).
    set_addr(0, 5'd7);
    bus.req_valid = 4'b0001;
    #1;
    check_eq("fwd_ready", 32'(bus.req_ready), 32'b0001);
    step();
    bus.req_valid = '0;
    check_eq("fwd_mux_sel", 32'(bus.mux_sel), 32'd7);
    bus.wr_en = 1'b1;
    bus.wr_addr = 5'd7;
    bus.wr_data = 32'h1234_5678;
    mux_force_en = 1'b1;
    mux_force = 32'h0;
    step();
    check_eq("fwd_rsp_valid", 32'(bus.rsp_valid), 32'b0001);
    check_eq("fwd_rsp_data",  bus.rsp_data, 32'h1234_5678);
    bus.wr_en = 1'b0;
    mux_force_en = 1'b0;

    // Address 0 must not forward (requester 1).
    set_addr(1, 5'd0);
    bus.req_valid = 4'b0010;
    #1;
    check_eq("zero_ready", 32'(bus.req_ready), 32'b0010);
    step();
    bus.req_valid = '0;
    check_eq("zero_mux_sel", 32'(bus.mux_sel), 32'd0);
    bus.wr_en = 1'b1;
    bus.wr_addr = 5'd0;
    bus.wr_data = 32'h1234_5678;
    step();
    check_eq("zero_rsp_valid", 32'(bus.rsp_valid), 32'b0010);
    check_eq("zero_rsp_data",  bus.rsp_data, 32'hDEAD_0000);
    bus.wr_en = 1'b0;

    // Idle gaps: requester 1 alone, address 20 then 21.
    set_addr(1, 5'd20);
    bus.req_valid = 4'b0010;
    #1;
    check_eq("idle_ready1", 32'(bus.req_ready), 32'b0010);
    step();
    bus.req_valid = '0;
    step();
    check_eq("idle_rsp1_valid", 32'(bus.rsp_valid), 32'b0010);
    check_eq("idle_rsp1_data",  bus.rsp_data, 32'hDEAD_0014);
    for (int k = 0; k < 3; k++) begin
      step();
      check_eq("gap_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check_eq("gap_rsp_data",  bus.rsp_data, 32'hDEAD_0014);
      check_eq("gap_ready",     32'(bus.req_ready), 32'd0);
      check_eq("gap_mux_sel",   32'(bus.mux_sel), 32'd20);
    end
    set_addr(1, 5'd21);
    bus.req_valid = 4'b0010;
    #1;
    check_eq("idle_ready2", 32'(bus.req_ready), 32'b0010);
    step();
    bus.req_valid = '0;
    check_eq("idle_mux_sel2", 32'(bus.mux_sel), 32'd21);
    step();
    check_eq("idle_rsp2_valid", 32'(bus.rsp_valid), 32'b0010);
    check_eq("idle_rsp2_data",  bus.rsp_data, 32'hDEAD_0015);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
